// File: rtl/dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dbg_pkg
//  Purpose  : Shared types and constants for the debug display sequencer:
//             read-source and FSM state enums, display marker values,
//             default table depths and the mode_i -> source decoder.
//  Revision : 1.0  initial release
// ============================================================================
package dbg_pkg;

    // Read source selector as presented on rd_src_o
    typedef enum logic [1:0] {
        SRC_ROM = 2'd0,
        SRC_RF  = 2'd1,
        SRC_ALU = 2'd2,
        SRC_DM  = 2'd3
    } src_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_SHOW = 3'd3,
        ST_MARK = 3'd4
    } state_e;

    localparam int          C_ADDR_W        = 7;
    localparam logic [31:0] C_MARKER        = 32'hFFFF_FFFF;
    localparam logic [31:0] C_TIMEOUT_VAL   = 32'hDEAD_DEAD;

    localparam int          C_DEF_ROM_DEPTH = 128;
    localparam int          C_DEF_RF_DEPTH  = 32;
    localparam int          C_DEF_ALU_ITEMS = 4;
    localparam int          C_DEF_DM_DEPTH  = 128;
    localparam int          C_DEF_TIMEOUT   = 15;

    // One-hot view select {rom, rf, alu, dm}; anything not one-hot falls back to ROM
    function automatic src_e decode_src(input logic [3:0] mode);
        src_e src;
        src = SRC_ROM;
        case (mode)
            4'b0100: src = SRC_RF;
            4'b0010: src = SRC_ALU;
            4'b0001: src = SRC_DM;
            default: src = SRC_ROM;
        endcase
        return src;
    endfunction

endpackage : dbg_pkg
`default_nettype wire

// File: rtl/dbg_wrap_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : dbg_wrap_cnt
//  Purpose  : Entry address counter for the debug sequencer. Advances on inc
//             until it reaches 'last', where it parks and raises 'done' so
//             the sequencer can emit one marker frame before wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module dbg_wrap_cnt #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    // Address / done register: clear wins, last entry parks and flags done
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr <= '0;
            done <= 1'b0;
        end else if (clr) begin
            addr <= '0;
            done <= 1'b0;
        end else if (inc) begin
            if (addr == last) begin
                done <= 1'b1;
            end else begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule : dbg_wrap_cnt
`default_nettype wire

// File: rtl/dbg_disp_seq.sv
`default_nettype none
// ============================================================================
//  Module   : dbg_disp_seq
//  Purpose  : Debug display sequencer. On each slow step pulse it reads the
//             next entry of the selected view (ROM / RF / ALU / DM) through a
//             shared read port and presents it to the seg7 driver. A marker
//             frame is shown once per wrap; unanswered reads time out with a
//             recognisable pattern.
//  Revision : 1.0  initial release
// ============================================================================
module dbg_disp_seq
    import dbg_pkg::*;
#(
    parameter int ROM_DEPTH = C_DEF_ROM_DEPTH,
    parameter int RF_DEPTH  = C_DEF_RF_DEPTH,
    parameter int ALU_ITEMS = C_DEF_ALU_ITEMS,
    parameter int DM_DEPTH  = C_DEF_DM_DEPTH,
    parameter int TIMEOUT   = C_DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  mode_i,
    input  logic        hold_i,
    input  logic        step_i,
    output logic        rd_req_o,
    output logic [1:0]  rd_src_o,
    output logic [6:0]  rd_addr_o,
    input  logic        rd_ack_i,
    input  logic [31:0] rd_data_i,
    output logic [31:0] disp_data_o,
    output logic        disp_valid_o,
    output logic        busy_o
);

    localparam int ADDR_W = C_ADDR_W;
    localparam int TW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e            state;
    state_e            state_nxt;
    src_e              cur_src;
    src_e              mode_src;
    logic              mode_chg;
    logic              abort;
    logic              abort_now;
    logic [TW-1:0]     tcnt;
    logic              tmo;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] last;
    logic              done;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              src_load;
    logic              load_data;
    logic [31:0]       data_nxt;

    assign mode_src  = decode_src(mode_i);
    assign mode_chg  = (mode_src != cur_src);
    assign abort_now = abort | mode_chg;
    assign tmo       = (tcnt == TW'(TIMEOUT - 1));

    assign rd_req_o     = (state == ST_REQ) || (state == ST_WAIT);
    assign rd_src_o     = cur_src;
    assign rd_addr_o    = addr;
    assign disp_valid_o = (state == ST_SHOW) || (state == ST_MARK);
    assign busy_o       = (state != ST_IDLE);

    // Last valid index of the view currently latched
    always_comb begin
        last = ADDR_W'(ROM_DEPTH - 1);
        case (cur_src)
            SRC_RF:  last = ADDR_W'(RF_DEPTH - 1);
            SRC_ALU: last = ADDR_W'(ALU_ITEMS - 1);
            SRC_DM:  last = ADDR_W'(DM_DEPTH - 1);
            default: last = ADDR_W'(ROM_DEPTH - 1);
        endcase
    end

    dbg_wrap_cnt #(
        .ADDR_W (ADDR_W)
    ) u_wrap_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .last (last),
        .addr (addr),
        .done (done)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        src_load  = 1'b0;
        load_data = 1'b0;
        data_nxt  = C_MARKER;
        case (state)
            ST_IDLE: begin
                if (mode_chg) begin
                    // New view: restart at entry 0, this step (if any) is dropped
                    src_load = 1'b1;
                    cnt_clr  = 1'b1;
                end else if (step_i) begin
                    if (done) begin
                        state_nxt = ST_MARK;
                        load_data = 1'b1;
                        data_nxt  = C_MARKER;
                    end else begin
                        state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ, ST_WAIT: begin
                // An ack always beats a coincident timeout
                if (rd_ack_i || ((state == ST_WAIT) && tmo)) begin
                    if (abort_now) begin
                        // View changed mid-read: swallow the result and restart
                        state_nxt = ST_IDLE;
                        cnt_clr   = 1'b1;
                        src_load  = 1'b1;
                    end else begin
                        state_nxt = ST_SHOW;
                        load_data = 1'b1;
                        data_nxt  = rd_ack_i ? rd_data_i : C_TIMEOUT_VAL;
                    end
                end else if (state == ST_REQ) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_SHOW: begin
                cnt_inc   = ~hold_i;
                state_nxt = ST_IDLE;
            end
            ST_MARK: begin
                cnt_clr   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latched view, display data, abort flag and wait-cycle counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_src     <= SRC_ROM;
            disp_data_o <= C_MARKER;
            abort       <= 1'b0;
            tcnt        <= '0;
        end else begin
            if (src_load) begin
                cur_src <= mode_src;
            end
            if (load_data) begin
                disp_data_o <= data_nxt;
            end
            if (state == ST_IDLE) begin
                abort <= 1'b0;
            end else if (rd_req_o && mode_chg) begin
                abort <= 1'b1;
            end
            tcnt <= (state == ST_WAIT) ? tcnt + TW'(1) : '0;
        end
    end

endmodule : dbg_disp_seq
`default_nettype wire
